i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (responder) with a small byte register file; the far end of the APB-driven I2C master.
//  Used in the apb2iic environment as the on-bus device model and synthesisable peripheral.
//  Decodes START/STOP, matches a 7-bit address, ACKs writes, and returns register data on reads.
//  Register pointer set by the first written byte after the address; auto-increments per data byte.
// PARAMETERS
//  TGT_ADDR   7'h50  7-bit I2C address this target answers to
//  PTR_W      2      register pointer width; register count NREG = 2**PTR_W
//  RST_VAL    8'h00  reset value of every register
// PORTS
//  PCLK        in   1          system clock; must be >= 8x SCL frequency
//  PRESETn     in   1          asynchronous active-low reset
//  SCL         in   1          I2C clock as seen on the bus (open-drain, externally pulled up)
//  SDA         in   1          I2C data as seen on the bus
//  SDA_ENABLE  out  1          1 = pull SDA low; 0 = release
//  REG_DATA    out  8*NREG     all registers, reg i at [8*i+7:8*i]
//  WR_STROBE   out  1          one-PCLK pulse when a data byte is written into a register
//  WR_PTR      out  PTR_W      register index written; valid with WR_STROBE
//  BUSY        out  1          1 from addressed START (match) until STOP or NACK termination
// BEHAVIOUR
//  Reset: SDA_ENABLE=0, WR_STROBE=0, WR_PTR=0, BUSY=0, all regs=RST_VAL, pointer=0, state IDLE.
//  Reset asserted mid-transfer: same values immediately (async); bus released.
//  Input path: SCL/SDA pass 2-flop synchroniser, then 1-flop edge detect -> 3 PCLK detect latency.
//  START: SDA fall while SCL high. STOP: SDA rise while SCL high. Detected in every state.
//  Bits sampled on SCL rise; SDA_ENABLE changes only on the PCLK after an SCL fall is detected.
//  States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE.
//   IDLE   -START-> ADDR (bit counter=0, shift reg cleared).
//   ADDR   8 bits MSB first (addr[6:0], R/W). On 8th SCL fall: match -> ADDR_ACK, SDA_ENABLE=1, BUSY=1;
//          mismatch -> IGNORE, SDA_ENABLE stays 0.
//   ADDR_ACK next SCL fall: R/W=0 -> PTR, release; R/W=1 -> RDATA, drive MSB of reg[pointer].
//   PTR    8 bits; pointer <= byte[PTR_W-1:0] (upper bits ignored); ACK -> PTR_ACK -> WDATA.
//   WDATA  8 bits; on 8th SCL fall: reg[pointer]<=byte, WR_STROBE=1 one cycle, WR_PTR=pointer,
//          pointer++ (wraps NREG-1 -> 0), SDA_ENABLE=1 -> WACK; next SCL fall release -> WDATA.
//   RDATA  drive SDA_ENABLE = ~bit for 8 bits; after 8th SCL fall release -> RACK; byte source
//          latched at byte start, pointer++ (wrap) when byte latched.
//   RACK   sample master ACK on SCL rise: SDA=0 -> RDATA (next byte); SDA=1 (NACK) -> IGNORE, BUSY=0.
//   IGNORE SDA_ENABLE=0; wait for START (-> ADDR) or STOP (-> IDLE).
//  STOP in any state -> IDLE, SDA_ENABLE=0, BUSY=0 on next PCLK; partial byte discarded.
//  Repeated START in any state -> ADDR; pointer retained (write-pointer-then-read sequence).
//  General call (addr 0) and 10-bit addressing not supported: treated as mismatch.
//  Target never stretches SCL. Pointer/registers unchanged by reads.
// TESTING
//  T1 write: S,0xA0,ptr 0x01,0xA5,0x3C,P -> ACK on all 4 bytes; reg1=A5, reg2=3C; 2 WR_STROBE pulses, WR_PTR 1 then 2.
//  T2 read: S,0xA0,0x01,Sr,0xA1, master ACK,NACK -> target sends 0xA5,0x3C; BUSY=0 after NACK; ends IDLE on P.
//  T3 mismatch: S,0xA2,0x55,P -> SDA_ENABLE never 1, regs unchanged, BUSY stays 0.
//  T4 wrap: S,0xA0,0x03,0x11,0x22,0x33,P -> reg3=11, reg0=22, reg1=33.
//  T5 abort: STOP mid-WDATA after 4 bits -> register not written, no WR_STROBE, state IDLE.
//  T6 reset: PRESETn low during RDATA with SDA_ENABLE=1 -> SDA_ENABLE=0 same cycle, all regs=RST_VAL.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// I2C bus wires between the bus master model and the target register block.
// SDA is the wired-AND bus value. SDA_ENABLE is the target's request to pull SDA low.
interface i2c_target_regs_if;
    logic SCL;
    logic SDA;
    logic SDA_ENABLE;

    modport master (output SCL, output SDA, input SDA_ENABLE);
    modport slave  (input SCL, input SDA, output SDA_ENABLE);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a small byte register file.
// The first written byte sets the register pointer; each data byte, written or read, advances it.
module i2c_target_regs #(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         PTR_W    = 2,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    i2c_target_regs_if.slave          bus,
    output logic [8*(2**PTR_W)-1:0]   REG_DATA,
    output logic                      WR_STROBE,
    output logic [PTR_W-1:0]          WR_PTR,
    output logic                      BUSY
);
    localparam int NREG = 2**PTR_W;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
    } state_t;

    state_t           state;
    logic [1:0]       scl_sync, sda_sync;
    logic             scl_d, sda_d;
    logic             scl_s, sda_s;
    logic             scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic [7:0]       tx_byte;
    logic             rw;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       regs [NREG];
    logic             sda_enable;

    // The synchroniser resets to the idle-bus level so that leaving reset creates no false edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.SCL};
            sda_sync <= {sda_sync[0], bus.SDA};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'd0;
            tx_byte    <= 8'd0;
            rw         <= 1'b0;
            ptr        <= '0;
            sda_enable <= 1'b0;
            WR_STROBE  <= 1'b0;
            WR_PTR     <= '0;
            BUSY       <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
        end else begin
            WR_STROBE <= 1'b0;
            if (stop_det) begin
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                sda_enable <= 1'b0;
                BUSY       <= 1'b0;
            end else if (start_det) begin
                // A repeated START keeps the pointer so that a read can follow a pointer write.
                state      <= ADDR;
                bit_cnt    <= 4'd0;
                shift      <= 8'd0;
                sda_enable <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            case (state)
                                ADDR: begin
                                    if (shift[7:1] == TGT_ADDR && shift[7:1] != 7'd0) begin
                                        state      <= ADDR_ACK;
                                        rw         <= shift[0];
                                        sda_enable <= 1'b1;
                                        BUSY       <= 1'b1;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end
                                PTR: begin
                                    state      <= PTR_ACK;
                                    ptr        <= shift[PTR_W-1:0];
                                    sda_enable <= 1'b1;
                                end
                                default: begin
                                    state      <= WACK;
                                    regs[ptr]  <= shift;
                                    WR_STROBE  <= 1'b1;
                                    WR_PTR     <= ptr;
                                    ptr        <= ptr + 1'b1;
                                    sda_enable <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state      <= RDATA;
                                tx_byte    <= {regs[ptr][6:0], 1'b0};
                                sda_enable <= ~regs[ptr][7];
                                ptr        <= ptr + 1'b1;
                                bit_cnt    <= 4'd1;
                            end else begin
                                state      <= PTR;
                                sda_enable <= 1'b0;
                                bit_cnt    <= 4'd0;
                            end
                        end
                    end
                    PTR_ACK, WACK: begin
                        if (scl_fall) begin
                            state      <= WDATA;
                            sda_enable <= 1'b0;
                            bit_cnt    <= 4'd0;
                        end
                    end
                    // bit_cnt counts bits already placed on the bus; 0 means a fresh byte is due.
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                tx_byte    <= {regs[ptr][6:0], 1'b0};
                                sda_enable <= ~regs[ptr][7];
                                ptr        <= ptr + 1'b1;
                                bit_cnt    <= 4'd1;
                            end else if (bit_cnt == 4'd8) begin
                                state      <= RACK;
                                sda_enable <= 1'b0;
                                bit_cnt    <= 4'd0;
                            end else begin
                                sda_enable <= ~tx_byte[7];
                                tx_byte    <= {tx_byte[6:0], 1'b0};
                                bit_cnt    <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd0;
                            if (!sda_s) begin
                                state <= RDATA;
                            end else begin
                                state <= IGNORE;
                                BUSY  <= 1'b0;
                            end
                        end
                    end
                    IGNORE: sda_enable <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        REG_DATA = '0;
        for (int i = 0; i < NREG; i++) REG_DATA[8*i +: 8] = regs[i];
    end

    assign bus.SDA_ENABLE = sda_enable;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: an I2C master model on an open-drain bus, directed scenarios
// followed by random transactions, all checked against an array-and-pointer register model.
module tb_i2c_target_regs;
    localparam logic [6:0] TGT = 7'h50;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic [31:0] reg_data;
    logic        wr_strobe;
    logic [1:0]  wr_ptr;
    logic        busy;

    i2c_target_regs_if bus ();

    assign bus.SCL = scl_drv;
    assign bus.SDA = sda_drv & ~bus.SDA_ENABLE;

    i2c_target_regs #(.TGT_ADDR(TGT), .PTR_W(2), .RST_VAL(8'h00)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .bus       (bus),
        .REG_DATA  (reg_data),
        .WR_STROBE (wr_strobe),
        .WR_PTR    (wr_ptr),
        .BUSY      (busy)
    );

    always #5 PCLK = ~PCLK;

    int          err_count = 0;
    int          check_count = 0;
    int          sda_en_cycles = 0;
    logic [7:0]  model_regs [4];
    int          model_ptr = 0;
    logic [7:0]  wbuf [4];
    logic [7:0]  last_read [4];
    logic [1:0]  strobe_q [$];

    always @(negedge PCLK) begin
        if (wr_strobe) strobe_q.push_back(wr_ptr);
        if (bus.SDA_ENABLE) sda_en_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] packRegs();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = model_regs[i];
        return v;
    endfunction

    task automatic waitClocks(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic busStart();
        sda_drv = 1'b1;
        waitClocks(6);
        sda_drv = 1'b0;
        waitClocks(6);
        scl_drv = 1'b0;
    endtask

    task automatic busRestart();
        waitClocks(6);
        sda_drv = 1'b1;
        waitClocks(6);
        scl_drv = 1'b1;
        waitClocks(6);
        sda_drv = 1'b0;
        waitClocks(6);
        scl_drv = 1'b0;
    endtask

    task automatic busStop();
        waitClocks(6);
        sda_drv = 1'b0;
        waitClocks(6);
        scl_drv = 1'b1;
        waitClocks(6);
        sda_drv = 1'b1;
        waitClocks(10);
    endtask

    // One SCL period (22 PCLK): data changes mid-low, bus sampled mid-high.
    task automatic clockBit(input logic b, output logic sampled);
        waitClocks(6);
        sda_drv = b;
        waitClocks(6);
        scl_drv = 1'b1;
        waitClocks(5);
        sampled = bus.SDA;
        waitClocks(5);
        scl_drv = 1'b0;
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(b[i], s);
        clockBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic readByte(output logic [7:0] b, input logic master_ack);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clockBit(1'b1, s);
            b = {b[6:0], s};
        end
        clockBit(~master_ack, s);
    endtask

    task automatic applyStimulus(input string tag, input logic [6:0] addr, input bit is_read,
                                 input bit set_ptr, input logic [7:0] ptr_byte, input int nbytes);
        logic       ack;
        logic       matched;
        logic [7:0] b;
        matched = (addr == TGT);
        busStart();
        if (!is_read || set_ptr) begin
            writeByte({addr, 1'b0}, ack);
            checkOutput({tag, "_addr_ack"}, ack, matched);
            checkOutput({tag, "_busy"}, busy, matched);
            writeByte(ptr_byte, ack);
            checkOutput({tag, "_ptr_ack"}, ack, matched);
            if (matched) model_ptr = ptr_byte % 4;
        end
        if (!is_read) begin
            for (int k = 0; k < nbytes; k++) begin
                writeByte(wbuf[k], ack);
                checkOutput({tag, "_data_ack"}, ack, matched);
                if (matched) begin
                    checkOutput({tag, "_strobe_cnt"}, strobe_q.size(), 1);
                    if (strobe_q.size() > 0) checkOutput({tag, "_wr_ptr"}, strobe_q.pop_front(), model_ptr);
                    model_regs[model_ptr] = wbuf[k];
                    model_ptr = (model_ptr + 1) % 4;
                end
            end
        end else begin
            if (set_ptr) busRestart();
            writeByte({addr, 1'b1}, ack);
            checkOutput({tag, "_raddr_ack"}, ack, matched);
            if (matched) begin
                for (int k = 0; k < nbytes; k++) begin
                    readByte(b, k != nbytes - 1);
                    last_read[k] = b;
                    checkOutput({tag, "_rdata"}, b, model_regs[model_ptr]);
                    model_ptr = (model_ptr + 1) % 4;
                end
                checkOutput({tag, "_nack_busy"}, busy, 0);
            end
        end
        busStop();
        checkOutput({tag, "_end_busy"}, busy, 0);
        checkOutput({tag, "_end_sda"}, bus.SDA_ENABLE, 0);
        checkOutput({tag, "_end_strobes"}, strobe_q.size(), 0);
        checkOutput({tag, "_regs"}, reg_data, packRegs());
    endtask

    initial begin
        logic       ack;
        logic       s;
        int         snap;
        logic [6:0] addr;
        int         kind;

        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
        waitClocks(4);
        checkOutput("rst_sda", bus.SDA_ENABLE, 0);
        checkOutput("rst_strobe", wr_strobe, 0);
        checkOutput("rst_wr_ptr", wr_ptr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_regs", reg_data, 0);
        PRESETn = 1'b1;
        waitClocks(5);

        // T1: pointer 1, then two data bytes.
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h3C;
        applyStimulus("t1", TGT, 0, 1, 8'h01, 2);
        checkOutput("t1_reg1", reg_data[15:8], 8'hA5);
        checkOutput("t1_reg2", reg_data[23:16], 8'h3C);

        // T2: set pointer 1, repeated START, read two bytes (ACK then NACK).
        applyStimulus("t2", TGT, 1, 1, 8'h01, 2);
        checkOutput("t2_byte0", last_read[0], 8'hA5);
        checkOutput("t2_byte1", last_read[1], 8'h3C);

        // T3: wrong address and general call are never acknowledged.
        snap = sda_en_cycles;
        applyStimulus("t3", 7'h51, 0, 1, 8'h55, 0);
        applyStimulus("t3gc", 7'h00, 0, 1, 8'h02, 1);
        checkOutput("t3_no_drive", sda_en_cycles - snap, 0);

        // T4: pointer wraps from 3 to 0.
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wbuf[2] = 8'h33;
        applyStimulus("t4", TGT, 0, 1, 8'h03, 3);
        checkOutput("t4_reg3", reg_data[31:24], 8'h11);
        checkOutput("t4_reg0", reg_data[7:0], 8'h22);
        checkOutput("t4_reg1", reg_data[15:8], 8'h33);

        // T5: STOP after four data bits discards the partial byte.
        busStart();
        writeByte({TGT, 1'b0}, ack);
        checkOutput("t5_addr_ack", ack, 1);
        writeByte(8'h02, ack);
        checkOutput("t5_ptr_ack", ack, 1);
        model_ptr = 2;
        for (int i = 0; i < 4; i++) clockBit(i[0], s);
        busStop();
        checkOutput("t5_strobes", strobe_q.size(), 0);
        checkOutput("t5_regs", reg_data, packRegs());
        checkOutput("t5_busy", busy, 0);

        // T6: reset while the target drives a 0 bit (reg0 = 0x22, MSB 0).
        busStart();
        writeByte({TGT, 1'b0}, ack);
        writeByte(8'h00, ack);
        busRestart();
        writeByte({TGT, 1'b1}, ack);
        checkOutput("t6_raddr_ack", ack, 1);
        waitClocks(6);
        checkOutput("t6_driving", bus.SDA_ENABLE, 1);
        @(posedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("t6_sda", bus.SDA_ENABLE, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_regs", reg_data, 0);
        sda_drv = 1'b1;
        waitClocks(2);
        scl_drv = 1'b1;
        waitClocks(4);
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        waitClocks(5);

        // Random traffic: writes, pointer-then-read, plain reads, occasional foreign address.
        for (int t = 0; t < 14; t++) begin
            kind = int'($urandom_range(0, 2));
            addr = TGT;
            if ($urandom_range(0, 4) == 0) begin
                addr = 7'($urandom_range(0, 127));
                if (addr == TGT) addr = TGT ^ 7'h01;
            end
            for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
            if (kind == 0)
                applyStimulus("rnd_wr", addr, 0, 1, 8'($urandom), int'($urandom_range(0, 3)));
            else
                applyStimulus("rnd_rd", addr, 1, kind == 2, 8'($urandom), int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end
endmodule
